bus_receiver: RTL and testbench
===============================

# bus_receiver

Receiving end of the shared tristate data bus. Any tristate driver on the bus places a word on it and pulses a one-cycle strobe; this block samples the bus on that strobe and queues the word in a small synchronous FIFO. It presents the queued words to a local consumer over a valid/ready interface. It also flags lost words (overflow) and, optionally, bus parity errors.

## Interface
- BUS_WIDTH, 32, width of the shared data bus and of every stored word
- DEPTH, 4, FIFO depth in words; power of two, minimum 2
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bus_in  input  BUS_WIDTH  shared bus value; only meaningful while bus_strobe is high
- bus_strobe  input  1  one-cycle pulse from the active driver: bus_in holds a valid word this cycle
- bus_parity  input  1  even-parity bit accompanying bus_in (present only with parity enabled)
- out_data  output  BUS_WIDTH  head-of-FIFO word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts out_data this cycle
- count  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH
- overflow  output  1  sticky: at least one strobed word was dropped
- parity_err  output  1  sticky: at least one strobed word failed parity (present only with parity enabled)
- clr_flags  input  1  clears overflow and parity_err; has no effect on FIFO contents

## Operation
- Write: on a clock edge with bus_strobe=1 and the word accepted, bus_in is written at the write pointer and the write pointer advances.
- Read: a pop occurs when out_valid=1 and out_ready=1. The read pointer advances and out_data shows the next word.
- out_valid = (count != 0). out_data is driven from FIFO storage at the read pointer. Its value is don't-care while out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count tracks occupancy explicitly.
- Full (count==DEPTH), strobe without pop: the word is dropped, count stays DEPTH, and overflow is set.
- Full, strobe with pop in the same cycle: the pop frees a slot, the write is accepted, count stays DEPTH, and overflow is not set.
- Empty, strobe with out_ready=1: no pop, because out_valid is 0. The word is stored and count becomes 1.
- Strobe and pop in the same cycle at non-boundary occupancy: count is unchanged.
- clr_flags coinciding with a new overflow or parity event: the set wins and the flag stays 1.
- bus_strobe is sampled every cycle. Back-to-back strobes are legal, and each is a separate word.
- Reset mid-operation: all stored words are discarded and pointers return to 0. No partial state survives.

## Timing
- Reset values: out_valid=0, count=0, overflow=0, parity_err=0, out_data=0, pointers=0.
- Latency: a strobe at edge N into an empty FIFO gives out_valid=1 and out_data=word after edge N (visible in cycle N+1).
- Throughput: one write and one pop per cycle, sustained.
- count, overflow and parity_err update on the same edge as the event that causes them.
- There are no combinational paths from bus_in or bus_strobe to any output. out_ready affects outputs only after the next edge.

## Configuration
- Macro: BUS_RECEIVER_PARITY_EN.
- With the macro defined:
  - The bus_parity input and parity_err output exist.
  - A strobed word where ^{bus_parity, bus_in} == 1 is not stored, and parity_err is set.
  - The parity check takes precedence over the full check: a bad word into a full FIFO sets parity_err only, not overflow.
- Without the macro: the port and output are absent, every strobed word is treated as good, and the logic compiles out entirely.

## Structure
- Shared package bus_pkg holds:
  - the default BUS_WIDTH constant (32), shared with the tristate drivers;
  - the ptr_width function, returning $clog2(DEPTH);
  - the occupancy-width rule, $clog2(DEPTH)+1.
- One sub-module, sync_fifo_mem: the DEPTH x BUS_WIDTH storage array with one synchronous write port and one asynchronous read port addressed by the read pointer.
- Pointers, count, flags and the parity check stay in bus_receiver.

## Test plan
- Reset then idle: out_valid=0, count=0, overflow=0 for 10 cycles with out_ready=1.
- Single word: strobe bus_in=0xDEADBEEF at edge N with out_ready=0 → out_valid=1 and out_data=0xDEADBEEF in cycle N+1, count=1. Raise out_ready → count=0 and out_valid=0 after the next edge.
- Fill and overflow (DEPTH=4, out_ready=0): strobe 0x1, 0x2, 0x3, 0x4, 0x5 on consecutive cycles → count=4 and overflow=1. Drain in order: 0x1, 0x2, 0x3, 0x4; 0x5 is absent.
- Full with simultaneous strobe and pop: at count=4, strobe 0xA5 with out_ready=1 → count stays 4, overflow stays 0, and 0xA5 emerges fourth after the pop.
- Wrap-around: 10 strobe+pop pairs with values 0..9 → output sequence 0..9 intact. Pulse clr_flags after an overflow → overflow=0 on the next edge.
- Parity (macro defined): strobe 0x00000001 with bus_parity=0 → parity_err=1 and count unchanged. Then strobe 0x00000001 with bus_parity=1 → stored, count=1.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants and sizing helpers used by the bus receiver and the tristate drivers.
package bus_pkg;

   localparam int unsigned BUS_WIDTH_DEF = 32;

   // Pointer width for a power-of-two FIFO depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x W storage array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_receiver.sv
// Samples the shared tristate bus on its strobe and queues words for a valid/ready consumer.
// Optional parity checking is enabled by defining BUS_RECEIVER_PARITY_EN.
module bus_receiver
   import bus_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [BUS_WIDTH-1:0]        bus_in,
   input  logic                        bus_strobe,
`ifdef BUS_RECEIVER_PARITY_EN
   input  logic                        bus_parity,
`endif
   output logic [BUS_WIDTH-1:0]        out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic                        overflow,
`ifdef BUS_RECEIVER_PARITY_EN
   output logic                        parity_err,
`endif
   input  logic                        clr_flags
);

   localparam int unsigned AW = ptr_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_d;
   logic [BUS_WIDTH-1:0] rd_data;
   logic                 pop;
   logic                 full;
   logic                 good;
   logic                 wr_en;
   logic                 ovf_set;
`ifdef BUS_RECEIVER_PARITY_EN
   logic                 perr_set;
`endif

   // Accept/drop decision: a pop in the same cycle frees the slot a full FIFO needs.
   always_comb begin
      pop     = out_valid & out_ready;
      full    = (count == CW'(DEPTH));
      good    = 1'b1;
`ifdef BUS_RECEIVER_PARITY_EN
      good     = ~(^{bus_parity, bus_in});
      perr_set = bus_strobe & ~good;
`endif
      wr_en   = bus_strobe & good & (~full | pop);
      ovf_set = bus_strobe & good & full & ~pop;
      count_d = count + CW'(wr_en) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
`ifdef BUS_RECEIVER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count     <= count_d;
         out_valid <= (count_d != '0);
         // A new event in the same cycle as a clear keeps the flag set.
         overflow  <= ovf_set | (overflow & ~clr_flags);
`ifdef BUS_RECEIVER_PARITY_EN
         parity_err <= perr_set | (parity_err & ~clr_flags);
`endif
      end
   end

   sync_fifo_mem #(
      .W     (BUS_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en & ~reset),
      .waddr (wr_ptr),
      .wdata (bus_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   // Storage is never reset, so present zero whenever nothing valid is queued.
   assign out_data = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_bus_receiver.sv
// Self-checking bench for bus_receiver: directed scenarios plus randomized traffic against a queue model.
module tb_bus_receiver;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  bus_in;
   logic          bus_strobe;
   logic          bus_parity;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    count;
   logic          overflow;
   logic          parity_err;
   logic          clr_flags;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic [W-1:0] mq[$];
   bit           m_ovf;
   bit           m_perr;

   always #5 clk = ~clk;

   bus_receiver #(
      .BUS_WIDTH (W),
      .DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_in     (bus_in),
      .bus_strobe (bus_strobe),
`ifdef BUS_RECEIVER_PARITY_EN
      .bus_parity (bus_parity),
`endif
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .overflow   (overflow),
`ifdef BUS_RECEIVER_PARITY_EN
      .parity_err (parity_err),
`endif
      .clr_flags  (clr_flags)
   );

`ifndef BUS_RECEIVER_PARITY_EN
   assign parity_err = 1'b0;
`endif

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue plus two sticky flags, advanced on each rising edge.
   always @(posedge clk) begin
      bit pop;
      bit good;
      bit full;
      if (reset) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_perr = 1'b0;
      end else begin
         pop  = (mq.size() != 0) && out_ready;
         full = (mq.size() == DEPTH);
         good = 1'b1;
`ifdef BUS_RECEIVER_PARITY_EN
         good = ($countones({bus_parity, bus_in}) % 2) == 0;
`endif
         if (pop) mq.delete(0);
         if (bus_strobe && good && (!full || pop)) mq.push_back(bus_in);
         if (bus_strobe && good && full && !pop) m_ovf = 1'b1;
         else if (clr_flags)                     m_ovf = 1'b0;
         if (bus_strobe && !good) m_perr = 1'b1;
         else if (clr_flags)      m_perr = 1'b0;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", W'(out_valid), W'(mq.size() != 0));
         check("m_count", W'(count), W'(mq.size()));
         check("m_ovf", W'(overflow), W'(m_ovf));
         check("m_perr", W'(parity_err), W'(m_perr));
         if (mq.size() != 0) check("m_data", out_data, mq[0]);
      end
   end

   // One clock of stimulus; starts and ends just after a falling edge.
   task automatic cyc(input bit s, input logic [W-1:0] d, input bit rdy,
                      input bit clr = 1'b0, input bit par_bad = 1'b0);
      bus_strobe = s;
      bus_in     = d;
      bus_parity = (^d) ^ par_bad;
      out_ready  = rdy;
      clr_flags  = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(0, '0, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; bus_in = '0; bus_strobe = 1'b0; bus_parity = 1'b0;
      out_ready = 1'b0; clr_flags = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      reset  = 1'b0;

      // Reset state and idle.
      check("rst_valid", W'(out_valid), 0);
      check("rst_count", W'(count), 0);
      check("rst_ovf", W'(overflow), 0);
      check("rst_data", out_data, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, '0, 1);
         check("idle_valid", W'(out_valid), 0);
      end

      // Single word latency and pop.
      cyc(1, 32'hDEADBEEF, 0);
      check("single_valid", W'(out_valid), 1);
      check("single_data", out_data, 32'hDEADBEEF);
      check("single_count", W'(count), 1);
      cyc(0, '0, 1);
      check("single_pop_count", W'(count), 0);
      check("single_pop_valid", W'(out_valid), 0);

      // Fill and overflow.
      for (int i = 1; i <= 5; i++) cyc(1, W'(i), 0);
      check("fill_count", W'(count), 4);
      check("fill_ovf", W'(overflow), 1);
      for (int i = 1; i <= 4; i++) begin
         check("drain_data", out_data, W'(i));
         cyc(0, '0, 1);
      end
      check("drain_empty", W'(count), 0);
      cyc(0, '0, 0, 1);
      check("clr_ovf", W'(overflow), 0);

      // Full with simultaneous strobe and pop.
      for (int i = 0; i < 4; i++) cyc(1, W'(32'h11 + i), 0);
      cyc(1, 32'hA5, 1);
      check("fullpop_count", W'(count), 4);
      check("fullpop_ovf", W'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         check("fullpop_data", out_data, (i == 3) ? 32'hA5 : W'(32'h12 + i));
         cyc(0, '0, 1);
      end

      // Wrap-around with one write and one pop per cycle.
      for (int k = 0; k < 10; k++) begin
         if (k > 0) check("wrap_data", out_data, W'(k - 1));
         cyc(1, W'(k), 1);
      end
      check("wrap_last", out_data, 9);
      cyc(0, '0, 1);
      check("wrap_empty", W'(count), 0);

      // Overflow set coinciding with clear: set wins.
      for (int i = 0; i < 4; i++) cyc(1, W'(32'h21 + i), 0);
      cyc(1, 32'h25, 0, 1);
      check("setwins_ovf", W'(overflow), 1);
      cyc(0, '0, 0, 1);
      check("clr2_ovf", W'(overflow), 0);
      check("clr2_count", W'(count), 4);

      // Reset mid-operation discards everything.
      do_reset();
      check("midrst_count", W'(count), 0);
      check("midrst_valid", W'(out_valid), 0);

`ifdef BUS_RECEIVER_PARITY_EN
      cyc(1, 32'h1, 0, 0, 1);
      check("par_bad_err", W'(parity_err), 1);
      check("par_bad_count", W'(count), 0);
      cyc(1, 32'h1, 0, 0, 0);
      check("par_good_count", W'(count), 1);
      do_reset();
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1),
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 2);
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
